// File: rtl/cms_pix28_package.sv
// Shared constants for the IP2 scan-chain data register: chain geometry,
// counter sizing and the terminal-count clamp.
package cms_pix28_package;

  localparam int SCAN_LEN         = 768;
  localparam int WORD_W           = 32;
  localparam int NWORDS           = SCAN_LEN / WORD_W;
  localparam int CNT_W            = 11;
  localparam int AW               = 5;
  localparam int IP2_TEST_LEN_MAX = 2 * SCAN_LEN;

  localparam logic [CNT_W-1:0] TEST_LEN_MAX_C = CNT_W'(IP2_TEST_LEN_MAX);
  localparam logic [AW-1:0]    NWORDS_A       = AW'(NWORDS);

  // A zero-length test is promoted to one shift; longer requests saturate.
  function automatic logic [CNT_W-1:0] clamp_cnt_max(input logic [CNT_W-1:0] v);
    if (v == '0)            return CNT_W'(1);
    if (v > TEST_LEN_MAX_C) return TEST_LEN_MAX_C;
    return v;
  endfunction

endpackage

// File: rtl/ip2_scanchain_reg_if.sv
// Firmware / sequencer / ASIC-side signal bundle of the scan-chain register.
interface ip2_scanchain_reg_if;
  import cms_pix28_package::*;

  logic              enable;
  logic              cfg_wr_en;
  logic [AW-1:0]     cfg_wr_addr;
  logic [WORD_W-1:0] cfg_wr_data;
  logic [CNT_W-1:0]  cfg_shift_cnt_max;
  logic [AW-1:0]     rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic              scanchain_reg_load;
  logic              scanchain_reg_shift;
  logic              scan_out;
  logic              scanchain_reg_bit0;
  logic [CNT_W-1:0]  scanchain_reg_shift_cnt;
  logic [CNT_W-1:0]  scanchain_reg_shift_cnt_max;
  logic              overrun;

  modport master (
    output enable, cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_shift_cnt_max,
           rd_addr, scanchain_reg_load, scanchain_reg_shift, scan_out,
    input  rd_data, scanchain_reg_bit0, scanchain_reg_shift_cnt,
           scanchain_reg_shift_cnt_max, overrun
  );

  modport slave (
    input  enable, cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_shift_cnt_max,
           rd_addr, scanchain_reg_load, scanchain_reg_shift, scan_out,
    output rd_data, scanchain_reg_bit0, scanchain_reg_shift_cnt,
           scanchain_reg_shift_cnt_max, overrun
  );

endinterface

// File: rtl/ip2_scanchain_reg.sv
// Scan-chain data register: shadow pattern memory, right-shifting pattern
// image with serial bit 0, scan_out capture image and shift counter.
module ip2_scanchain_reg
  import cms_pix28_package::*;
(
  input  logic              clk,
  input  logic              reset_not,
  ip2_scanchain_reg_if.slave bus
);

  logic [NWORDS-1:0][WORD_W-1:0] shadow;
  logic [SCAN_LEN-1:0]           shift_img;
  logic [NWORDS-1:0][WORD_W-1:0] cap_img;
  logic [CNT_W-1:0]              cnt, cnt_max;
  logic                          ovr;
  logic [WORD_W-1:0]             rd_q;

  logic do_load, shift_req, do_shift, do_ovr;

  assign do_load   = bus.enable & bus.scanchain_reg_load;
  assign shift_req = bus.enable & bus.scanchain_reg_shift & ~bus.scanchain_reg_load;
  assign do_shift  = shift_req & (cnt < cnt_max);
  assign do_ovr    = shift_req & (cnt == cnt_max);

  // Firmware may rewrite the shadow at any time; only the next load sees it.
  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not)
      shadow <= '0;
    else if (bus.cfg_wr_en && (bus.cfg_wr_addr < NWORDS_A))
      shadow[bus.cfg_wr_addr] <= bus.cfg_wr_data;
  end

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      shift_img <= '0;
      cap_img   <= '0;
      cnt       <= '0;
      cnt_max   <= TEST_LEN_MAX_C;
      ovr       <= 1'b0;
    end else if (do_load) begin
      shift_img <= shadow;
      cap_img   <= '0;
      cnt       <= '0;
      cnt_max   <= clamp_cnt_max(bus.cfg_shift_cnt_max);
      ovr       <= 1'b0;
    end else if (do_shift) begin
      // Past SCAN_LEN shifts the image is all zeros and the capture keeps
      // only the most recent SCAN_LEN scan_out bits.
      shift_img <= {1'b0, shift_img[SCAN_LEN-1:1]};
      cap_img   <= {bus.scan_out, cap_img[NWORDS-1:0] } >> 1;
      cnt       <= cnt + CNT_W'(1);
    end else if (do_ovr) begin
      ovr       <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not)
      rd_q <= '0;
    else if (bus.rd_addr < NWORDS_A)
      rd_q <= cap_img[bus.rd_addr];
    else
      rd_q <= '0;
  end

  assign bus.scanchain_reg_bit0          = shift_img[0];
  assign bus.scanchain_reg_shift_cnt     = cnt;
  assign bus.scanchain_reg_shift_cnt_max = cnt_max;
  assign bus.overrun                     = ovr;
  assign bus.rd_data                     = rd_q;

endmodule

// File: tb/tb_ip2_scanchain_reg.sv
// Directed bench for ip2_scanchain_reg: load, loopback capture, overrun,
// load/shift priority, max clamping, enable freeze and async reset.
`timescale 1ns/1ps
module tb_ip2_scanchain_reg;
  import cms_pix28_package::*;

  logic clk = 1'b0;
  logic reset_not;
  int   checks = 0;
  int   errors = 0;

  ip2_scanchain_reg_if ifc ();

  ip2_scanchain_reg dut (
    .clk       (clk),
    .reset_not (reset_not),
    .bus       (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input int k);
    return (k == 0) ? 32'hA5A5_0001 : 32'hA5A5_0000 + 32'(k);
  endfunction

  task automatic wr(input int a, input logic [31:0] d);
    ifc.cfg_wr_en   = 1'b1;
    ifc.cfg_wr_addr = AW'(a);
    ifc.cfg_wr_data = d;
    tick();
    ifc.cfg_wr_en   = 1'b0;
  endtask

  task automatic load(input int mx, input logic with_shift);
    ifc.cfg_shift_cnt_max   = CNT_W'(mx);
    ifc.scanchain_reg_load  = 1'b1;
    ifc.scanchain_reg_shift = with_shift;
    tick();
    ifc.scanchain_reg_load  = 1'b0;
    ifc.scanchain_reg_shift = 1'b0;
  endtask

  // scan_out loops the currently presented pattern bit back into capture.
  task automatic shifts(input int n);
    for (int i = 0; i < n; i++) begin
      ifc.scanchain_reg_shift = 1'b1;
      ifc.scan_out            = ifc.scanchain_reg_bit0;
      tick();
    end
    ifc.scanchain_reg_shift = 1'b0;
    ifc.scan_out            = 1'b0;
  endtask

  initial begin
    reset_not               = 1'b0;
    ifc.enable              = 1'b0;
    ifc.cfg_wr_en           = 1'b0;
    ifc.cfg_wr_addr         = '0;
    ifc.cfg_wr_data         = '0;
    ifc.cfg_shift_cnt_max   = '0;
    ifc.rd_addr             = '0;
    ifc.scanchain_reg_load  = 1'b0;
    ifc.scanchain_reg_shift = 1'b0;
    ifc.scan_out            = 1'b0;
    repeat (2) tick();

    chk("rst_bit0",    32'(ifc.scanchain_reg_bit0), 32'd0);
    chk("rst_cnt",     32'(ifc.scanchain_reg_shift_cnt), 32'd0);
    chk("rst_cnt_max", 32'(ifc.scanchain_reg_shift_cnt_max), 32'd1536);
    chk("rst_overrun", 32'(ifc.overrun), 32'd0);
    chk("rst_rd_data", ifc.rd_data, 32'd0);

    reset_not  = 1'b1;
    ifc.enable = 1'b1;
    tick();
    for (int k = 0; k < 24; k++) wr(k, pat(k));

    load(768, 1'b0);
    chk("load_bit0",    32'(ifc.scanchain_reg_bit0), 32'd1);
    chk("load_cnt",     32'(ifc.scanchain_reg_shift_cnt), 32'd0);
    chk("load_cnt_max", 32'(ifc.scanchain_reg_shift_cnt_max), 32'd768);

    shifts(1);
    chk("shift1_bit0", 32'(ifc.scanchain_reg_bit0), 32'd0);
    chk("shift1_cnt",  32'(ifc.scanchain_reg_shift_cnt), 32'd1);
    shifts(767);
    chk("full_cnt",     32'(ifc.scanchain_reg_shift_cnt), 32'd768);
    chk("full_overrun", 32'(ifc.overrun), 32'd0);
    chk("full_bit0",    32'(ifc.scanchain_reg_bit0), 32'd0);

    for (int k = 0; k < 24; k++) begin
      ifc.rd_addr = AW'(k);
      tick();
      chk($sformatf("cap_w%0d", k), ifc.rd_data, pat(k));
    end
    ifc.rd_addr = AW'(24);
    tick();
    chk("cap_oor", ifc.rd_data, 32'd0);

    shifts(1);
    chk("ovr_cnt",  32'(ifc.scanchain_reg_shift_cnt), 32'd768);
    chk("ovr_bit0", 32'(ifc.scanchain_reg_bit0), 32'd0);
    chk("ovr_flag", 32'(ifc.overrun), 32'd1);
    ifc.rd_addr = AW'(3);
    tick();
    chk("ovr_cap_hold", ifc.rd_data, pat(3));

    load(768, 1'b0);
    chk("reload_ovr",  32'(ifc.overrun), 32'd0);
    chk("reload_bit0", 32'(ifc.scanchain_reg_bit0), 32'd1);
    tick();
    chk("reload_cap_clr", ifc.rd_data, 32'd0);

    shifts(5);
    chk("s5_cnt", 32'(ifc.scanchain_reg_shift_cnt), 32'd5);
    load(768, 1'b1);
    chk("ldsh_cnt",  32'(ifc.scanchain_reg_shift_cnt), 32'd0);
    chk("ldsh_bit0", 32'(ifc.scanchain_reg_bit0), 32'd1);

    load(0, 1'b0);
    chk("clamp_lo", 32'(ifc.scanchain_reg_shift_cnt_max), 32'd1);
    shifts(2);
    chk("clamp_lo_cnt", 32'(ifc.scanchain_reg_shift_cnt), 32'd1);
    chk("clamp_lo_ovr", 32'(ifc.overrun), 32'd1);

    load(2000, 1'b0);
    chk("clamp_hi", 32'(ifc.scanchain_reg_shift_cnt_max), 32'd1536);
    shifts(767);
    chk("s767_bit0", 32'(ifc.scanchain_reg_bit0), 32'd1);
    shifts(1);
    chk("s768_bit0", 32'(ifc.scanchain_reg_bit0), 32'd0);
    shifts(768);
    chk("s1536_cnt",  32'(ifc.scanchain_reg_shift_cnt), 32'd1536);
    chk("s1536_ovr",  32'(ifc.overrun), 32'd0);
    chk("s1536_bit0", 32'(ifc.scanchain_reg_bit0), 32'd0);
    ifc.rd_addr = AW'(5);
    tick();
    chk("s1536_cap", ifc.rd_data, 32'd0);

    // bit 304 is word 9 bit 16 (=1), bit 305 is word 9 bit 17 (=0)
    load(2000, 1'b0);
    shifts(304);
    chk("s304_bit0", 32'(ifc.scanchain_reg_bit0), 32'd1);
    ifc.enable              = 1'b0;
    ifc.scanchain_reg_shift = 1'b1;
    repeat (10) tick();
    chk("en_lo_cnt",  32'(ifc.scanchain_reg_shift_cnt), 32'd304);
    chk("en_lo_bit0", 32'(ifc.scanchain_reg_bit0), 32'd1);
    ifc.enable = 1'b1;
    shifts(1);
    chk("en_hi_cnt",  32'(ifc.scanchain_reg_shift_cnt), 32'd305);
    chk("en_hi_bit0", 32'(ifc.scanchain_reg_bit0), 32'd0);

    shifts(1);
    ifc.scanchain_reg_shift = 1'b1;
    ifc.rd_addr             = AW'(9);
    #2;
    reset_not = 1'b0;
    #1;
    chk("arst_cnt",     32'(ifc.scanchain_reg_shift_cnt), 32'd0);
    chk("arst_cnt_max", 32'(ifc.scanchain_reg_shift_cnt_max), 32'd1536);
    chk("arst_ovr",     32'(ifc.overrun), 32'd0);
    chk("arst_bit0",    32'(ifc.scanchain_reg_bit0), 32'd0);
    chk("arst_rd",      ifc.rd_data, 32'd0);
    ifc.scanchain_reg_shift = 1'b0;
    tick();
    reset_not = 1'b1;
    load(768, 1'b0);
    chk("arst_shadow_lost", 32'(ifc.scanchain_reg_bit0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
